obi_mem_arbiter: RTL
====================

OBI_MEM_ARBITER -- requirements
Module: obi_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width of all ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width of all ports; byte enables are DATA_WIDTH/8 bits.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 4, depth of the response route FIFO; must be a power of two and at least 2.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk_i  in  1  clock, rising edge; rst_i  in  1  synchronous active-high reset.
REQ-005 SHALL have instr_req_i in 1, instr_addr_i in ADDR_WIDTH, instr_gnt_o out 1, instr_rvalid_o out 1, instr_rdata_o out DATA_WIDTH: read-only instruction requester.
REQ-006 SHALL have data_req_i in 1, data_addr_i in ADDR_WIDTH, data_we_i in 1, data_be_i in DATA_WIDTH/8, data_wdata_i in DATA_WIDTH, data_gnt_o out 1, data_rvalid_o out 1, data_rdata_o out DATA_WIDTH: read/write data requester.
REQ-007 SHALL have mem_req_o out 1, mem_addr_o out ADDR_WIDTH, mem_we_o out 1, mem_be_o out DATA_WIDTH/8, mem_wdata_o out DATA_WIDTH, mem_gnt_i in 1, mem_rvalid_i in 1, mem_rdata_i in DATA_WIDTH: single shared memory port, in-order responses.
REQ-008 SHALL have outstanding_o out $clog2(MAX_OUTSTANDING)+1, the number of granted transactions still awaiting rvalid; protocol_err_o out 1, a sticky error flag.

Function
REQ-009 SHALL drive mem_req_o = (instr_req_i | data_req_i) & ~full & ~rst_i, combinationally.
REQ-010 SHALL select the requester as follows: when only one requests, that one; when both request, the one not granted last (round-robin pointer last_q).
REQ-011 SHALL lock the selection once mem_req_o is high without mem_gnt_i (lock_q=1, owner_q=selected), and keep it until the handshake cycle, so mem_addr_o, mem_we_o, mem_be_o and mem_wdata_o stay stable under backpressure.
REQ-012 SHALL mux the selected requester onto mem_*; for an instr selection, drive mem_we_o=0, mem_be_o=all ones and mem_wdata_o=0.
REQ-013 SHALL assert the selected requester's gnt = mem_req_o & mem_gnt_i, and hold the other requester's gnt at 0; at most one gnt is high per cycle.
REQ-014 SHALL, on a handshake (mem_req_o & mem_gnt_i), push the owner id into the route FIFO, set last_q to the owner, and clear lock_q, all at the next edge.
REQ-015 SHALL, on mem_rvalid_i with a non-empty FIFO, pop the head, and assert instr_rvalid_o or data_rvalid_o (the head owner's only) in the same cycle; both rdata outputs carry mem_rdata_i unconditionally.
REQ-016 SHALL, on a simultaneous push and pop, advance both pointers and leave outstanding_o unchanged.
REQ-017 SHALL treat full as outstanding_o == MAX_OUTSTANDING; while full, mem_req_o=0 and both gnts are 0, even when a pop occurs in the same cycle; the request is granted at the earliest one cycle after the pop.
REQ-018 SHALL, on mem_rvalid_i with an empty FIFO (including a same-cycle push), keep both rvalids at 0, perform no pop, and set protocol_err_o=1 until reset.
REQ-019 SHALL wrap the FIFO read/write pointers modulo MAX_OUTSTANDING.
REQ-020 SHALL keep the 1-cycle combinational path req->gnt; it adds no latency to requests or responses.

Reset
REQ-021 SHALL, while rst_i=1 at a rising edge: empty the FIFO, set outstanding_o=0, lock_q=0, protocol_err_o=0, and set last_q=instr so that data wins the first tie.
REQ-022 SHALL force mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o and data_rvalid_o to 0 during rst_i=1.
REQ-023 SHALL discard all in-flight routing when reset occurs mid-operation; responses arriving after reset release set protocol_err_o.

Verification
REQ-024 Reset, then both req in cycle 0 with mem_gnt_i=1 -> data_gnt_o=1 in cycle 0, instr_gnt_o=1 in cycle 1; then alternation data/instr/data while both stay asserted.
REQ-025 Lock: data req addr 0x100 selected with mem_gnt_i=0 for 3 cycles, instr req rising in cycle 1 -> mem_addr_o=0x100 for all 3 cycles; instr is granted in the cycle after data's handshake.
REQ-026 MAX_OUTSTANDING=4, mem_gnt_i=1, no rvalid, instr req continuous -> 4 grants, outstanding_o=4, mem_req_o=0; one rvalid -> instr_rvalid_o=1 that cycle, the next gnt one cycle later.
REQ-027 Order: grants instr, data, data, then 3 rvalids -> instr_rvalid_o, data_rvalid_o, data_rvalid_o in that order; outstanding_o goes 3->0.
REQ-028 Same-cycle grant and rvalid with outstanding_o=2 -> outstanding_o stays 2; rvalid with outstanding_o=0 -> both rvalids 0 and protocol_err_o=1 until rst_i.
REQ-029 Instr handshake -> mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0; data write 0xDEADBEEF with be 4'b0011 -> passed through unchanged.

Source files
------------

// File: rtl/obi_mem_arbiter.sv
// Two-requester OBI arbiter onto one in-order memory port.
// Round-robin ties, request locking under backpressure, response routing FIFO.
module obi_mem_arbiter #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic                                 instr_req_i,
   input  logic [ADDR_WIDTH-1:0]                instr_addr_i,
   output logic                                 instr_gnt_o,
   output logic                                 instr_rvalid_o,
   output logic [DATA_WIDTH-1:0]                instr_rdata_o,
   input  logic                                 data_req_i,
   input  logic [ADDR_WIDTH-1:0]                data_addr_i,
   input  logic                                 data_we_i,
   input  logic [DATA_WIDTH/8-1:0]              data_be_i,
   input  logic [DATA_WIDTH-1:0]                data_wdata_i,
   output logic                                 data_gnt_o,
   output logic                                 data_rvalid_o,
   output logic [DATA_WIDTH-1:0]                data_rdata_o,
   output logic                                 mem_req_o,
   output logic [ADDR_WIDTH-1:0]                mem_addr_o,
   output logic                                 mem_we_o,
   output logic [DATA_WIDTH/8-1:0]              mem_be_o,
   output logic [DATA_WIDTH-1:0]                mem_wdata_o,
   input  logic                                 mem_gnt_i,
   input  logic                                 mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0]                mem_rdata_i,
   output logic [$clog2(MAX_OUTSTANDING):0]     outstanding_o,
   output logic                                 protocol_err_o
);

   localparam int PW = $clog2(MAX_OUTSTANDING);
   localparam int CW = PW + 1;

   // Owner encoding: 0 = instr, 1 = data
   logic                       r_lock;
   logic                       r_owner;
   logic                       r_last;
   logic                       r_err;
   logic [MAX_OUTSTANDING-1:0] r_route;
   logic [PW-1:0]              r_wptr;
   logic [PW-1:0]              r_rptr;
   logic [CW-1:0]              r_cnt;

   logic w_full;
   logic w_empty;
   logic w_sel;
   logic w_hs;
   logic w_pop;
   logic w_head;

   assign w_full  = (r_cnt == CW'(MAX_OUTSTANDING));
   assign w_empty = (r_cnt == '0);

   always_comb begin
      w_sel = data_req_i;
      if (r_lock)
         w_sel = r_owner;
      else if (instr_req_i && data_req_i)
         w_sel = ~r_last;
   end

   assign mem_req_o   = (instr_req_i | data_req_i) & ~w_full & ~rst_i;
   assign w_hs        = mem_req_o & mem_gnt_i;

   assign mem_addr_o  = w_sel ? data_addr_i : instr_addr_i;
   assign mem_we_o    = w_sel & data_we_i;
   assign mem_be_o    = w_sel ? data_be_i : '1;
   assign mem_wdata_o = w_sel ? data_wdata_i : '0;

   assign instr_gnt_o = w_hs & ~w_sel;
   assign data_gnt_o  = w_hs & w_sel;

   assign w_head = r_route[r_rptr];
   assign w_pop  = mem_rvalid_i & ~w_empty & ~rst_i;

   assign instr_rvalid_o = w_pop & ~w_head;
   assign data_rvalid_o  = w_pop & w_head;
   assign instr_rdata_o  = mem_rdata_i;
   assign data_rdata_o   = mem_rdata_i;

   assign outstanding_o  = r_cnt;
   assign protocol_err_o = r_err;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_lock  <= 1'b0;
         r_owner <= 1'b0;
         r_last  <= 1'b0;
         r_err   <= 1'b0;
         r_route <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_cnt   <= '0;
      end else begin
         if (w_hs) begin
            r_route[r_wptr] <= w_sel;
            r_wptr          <= r_wptr + PW'(1);
            r_last          <= w_sel;
            r_lock          <= 1'b0;
         end else if (mem_req_o) begin
            // hold the choice so the memory sees stable request fields
            r_lock  <= 1'b1;
            r_owner <= w_sel;
         end
         if (w_pop)
            r_rptr <= r_rptr + PW'(1);
         case ({w_hs, w_pop})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: r_cnt <= r_cnt;
         endcase
         if (mem_rvalid_i && w_empty)
            r_err <= 1'b1;
      end
   end

endmodule
